// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared turn encodings and default timing constants for the snake key conditioner
// Contents: TURN_RIGHT / TURN_LEFT direction codes, default debounce and
// auto-repeat periods, and the turn queue depth.
package snake_pkg;

    localparam logic TURN_RIGHT = 1'b0;
    localparam logic TURN_LEFT  = 1'b1;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 20000;
    localparam int DEFAULT_REPEAT_CYCLES   = 400000;

    localparam int TURN_FIFO_DEPTH = 2;

endpackage

// File: rtl/snake_key_conditioner_if.sv
// rtl/snake_key_conditioner_if.sv - turn request handshake between the key conditioner and the snake core
// Signals:
//   turn_valid  a turn request is pending at the queue head
//   turn_dir    head request direction (TURN_RIGHT / TURN_LEFT)
//   turn_ready  the snake core accepts the head request this cycle
// Modports: master = conditioner side, slave = snake core side.
interface snake_key_conditioner_if;

    logic turn_valid;
    logic turn_dir;
    logic turn_ready;

    modport master (
        output turn_valid,
        output turn_dir,
        input  turn_ready
    );

    modport slave (
        input  turn_valid,
        input  turn_dir,
        output turn_ready
    );

endinterface

// File: rtl/snake_key_debounce.sv
// rtl/snake_key_debounce.sv - per-key synchronizer, debouncer and press pulse generator
// Ports:
//   clockInp  clock, rising edge
//   reset     synchronous active-high reset
//   key       raw asynchronous button, active-low
//   press     one-cycle pulse on each accepted press (and each auto-repeat)
// Optional feature: SNAKE_KEY_AUTOREPEAT_EN adds a repeat counter that
// re-fires press every REPEAT_CYCLES cycles while the key stays held.
module snake_key_debounce
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`ifdef SNAKE_KEY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
`endif
) (
    input  logic clockInp,
    input  logic reset,
    input  logic key,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] count;
    logic          accept;
    logic          repeat_fire;

    // The synchronized level has disagreed with the stable level for the
    // full debounce window once this cycle is counted.
    assign accept = (sync2 != stable) && (count == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clockInp) begin
        if (reset) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            count  <= '0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            if (sync2 == stable) begin
                count <= '0;
            end else if (accept) begin
                stable <= sync2;
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

`ifdef SNAKE_KEY_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    logic [RW-1:0] repeat_count;

    // Repeats only run while both the accepted and the synchronized level
    // are low, so a release that is still being debounced never fires one
    // last spurious repeat.
    assign repeat_fire = !stable && !sync2 && (repeat_count == RW'(REPEAT_CYCLES - 1));

    always_ff @(posedge clockInp) begin
        if (reset) begin
            repeat_count <= '0;
        end else if (stable || sync2 || repeat_fire) begin
            repeat_count <= '0;
        end else begin
            repeat_count <= repeat_count + 1'b1;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    // Only the 1 -> 0 stable transition is a press; releases are silent.
    always_ff @(posedge clockInp) begin
        if (reset) begin
            press <= 1'b0;
        end else begin
            press <= (accept && !sync2) || repeat_fire;
        end
    end

endmodule

// File: rtl/snake_key_conditioner.sv
// rtl/snake_key_conditioner.sv - debounces two turn buttons and queues turn requests for the snake core
// Ports:
//   clockInp  sole clock, rising edge
//   reset     synchronous active-high reset
//   KEY[1:0]  raw buttons, active-low; KEY[0] = turn right, KEY[1] = turn left
//   turn      snake_key_conditioner_if.master: turn_valid / turn_dir out, turn_ready in
//   overflow  sticky: a press was dropped because the 2-entry queue was full
// Optional feature: SNAKE_KEY_AUTOREPEAT_EN enables auto-repeat in each key debouncer.
module snake_key_conditioner
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic                            clockInp,
    input  logic                            reset,
    input  logic [1:0]                      KEY,
    snake_key_conditioner_if.master         turn,
    output logic                            overflow
);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("snake_key_conditioner: cycle parameters must be at least 1");
    end

    logic [1:0] press;

    for (genvar k = 0; k < 2; k++) begin : g_key
        snake_key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef SNAKE_KEY_AUTOREPEAT_EN
            ,
            .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
        ) u_debounce (
            .clockInp (clockInp),
            .reset    (reset),
            .key      (KEY[k]),
            .press    (press[k])
        );
    end

    // Event stage: simultaneous presses on both keys cancel each other
    // (an ambiguous request) and never reach the queue.
    logic evt_valid;
    logic evt_dir;

    always_ff @(posedge clockInp) begin
        if (reset) begin
            evt_valid <= 1'b0;
            evt_dir   <= TURN_RIGHT;
        end else begin
            evt_valid <= press[0] ^ press[1];
            evt_dir   <= press[1] ? TURN_LEFT : TURN_RIGHT;
        end
    end

    // Two-entry turn queue. A pop frees a slot in the same cycle, so a push
    // into a full queue still succeeds when the head is being consumed.
    logic [TURN_FIFO_DEPTH-1:0] mem;
    logic                       wr_ptr;
    logic                       rd_ptr;
    logic [1:0]                 occ;
    logic                       full;
    logic                       pop;
    logic                       push_ok;

    assign full    = (occ == 2'(TURN_FIFO_DEPTH));
    assign pop     = (occ != 2'd0) && turn.turn_ready;
    assign push_ok = evt_valid && (!full || pop);

    always_ff @(posedge clockInp) begin
        if (reset) begin
            mem      <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            occ      <= 2'd0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= evt_dir;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push_ok} - {1'b0, pop};
            if (evt_valid && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    assign turn.turn_valid = (occ != 2'd0);
    assign turn.turn_dir   = mem[rd_ptr];

endmodule
